// File: rtl/pipe_sched_if.sv
// Handshake and pipeline-side bundle for pipe_sched. The slave modport is the
// scheduler; the master modport is whatever drives operands, the pipeline model and the consumer.
interface pipe_sched_if #(
  parameter int LANES = 4
);
  localparam int LW = $clog2(LANES);

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_afmt;
  logic          in_bfmt;
  logic [LW-1:0] in_lane;
  logic          in_first;
  logic          in_last;

  logic          pipe_en;
  logic [7:0]    pipe_a;
  logic [7:0]    pipe_b;
  logic [15:0]   pipe_c;
  logic          pipe_afmt;
  logic          pipe_bfmt;
  logic          pipe_save;
  logic [15:0]   pipe_result;
  logic          pipe_saveout;

  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [LW-1:0] out_lane;
  logic          err;

  modport slave (
    input  in_valid, in_a, in_b, in_afmt, in_bfmt, in_lane, in_first, in_last,
    output in_ready,
    output pipe_en, pipe_a, pipe_b, pipe_c, pipe_afmt, pipe_bfmt, pipe_save,
    input  pipe_result, pipe_saveout,
    output out_valid, out_data, out_lane, err,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_afmt, in_bfmt, in_lane, in_first, in_last,
    input  in_ready,
    input  pipe_en, pipe_a, pipe_b, pipe_c, pipe_afmt, pipe_bfmt, pipe_save,
    output pipe_result, pipe_saveout,
    input  out_valid, out_data, out_lane, err,
    output out_ready
  );
endinterface

// File: rtl/pipe_sched.sv
// Issue controller for the FP8 MAC pipeline: per-lane accumulators fed back as C,
// RAW hazard stall across LAT cycles, and a single-entry result slot.

module pipe_sched_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (wr) q <= d;
endmodule

module pipe_sched #(
  parameter int LAT   = 4,
  parameter int LANES = 4
) (
  input logic       clk,
  input logic       rst,
  pipe_sched_if.slave bus
);
  localparam int LW = $clog2(LANES);

  logic                   accept, lane_hit, last_hit;
  logic [LAT-1:0]         vld_pipe, last_pipe;
  logic [LAT-1:0][LW-1:0] lane_pipe;
  logic [LANES-1:0][15:0] acc;
  logic                   wb, wb_last;
  logic [LW-1:0]          wb_lane;
  logic                   out_valid_q;

  assign wb      = vld_pipe[LAT-1];
  assign wb_last = last_pipe[LAT-1];
  assign wb_lane = lane_pipe[LAT-1];

  // The tail still blocks in its writeback cycle: no bypass from pipe_result to pipe_c.
  always_comb begin
    lane_hit = 1'b0;
    last_hit = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (vld_pipe[i] && lane_pipe[i] == bus.in_lane) lane_hit = 1'b1;
      if (vld_pipe[i] && last_pipe[i])                last_hit = 1'b1;
    end
  end

  assign bus.in_ready  = !rst && !lane_hit && !(bus.in_last && (out_valid_q || last_hit));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      lane_pipe <= '0;
    end else begin
      vld_pipe[0]  <= accept;
      last_pipe[0] <= bus.in_last;
      lane_pipe[0] <= bus.in_lane;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        lane_pipe[i] <= lane_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pipe_en   <= 1'b0;
      bus.pipe_a    <= '0;
      bus.pipe_b    <= '0;
      bus.pipe_c    <= '0;
      bus.pipe_afmt <= 1'b0;
      bus.pipe_bfmt <= 1'b0;
      bus.pipe_save <= 1'b0;
    end else begin
      bus.pipe_en <= accept;
      if (accept) begin
        bus.pipe_a    <= bus.in_a;
        bus.pipe_b    <= bus.in_b;
        bus.pipe_c    <= bus.in_first ? 16'h0000 : acc[bus.in_lane];
        bus.pipe_afmt <= bus.in_afmt;
        bus.pipe_bfmt <= bus.in_bfmt;
        bus.pipe_save <= bus.in_last;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pipe_sched_acc u_acc (
      .clk (clk),
      .rst (rst),
      .wr  (wb && wb_lane == LW'(l)),
      .d   (bus.pipe_result),
      .q   (acc[l])
    );
  end

  // A last writeback never lands while the slot is full, so set wins over clear safely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      bus.out_data <= '0;
      bus.out_lane <= '0;
      bus.err      <= 1'b0;
    end else begin
      if (wb && wb_last) begin
        out_valid_q  <= 1'b1;
        bus.out_data <= bus.pipe_result;
        bus.out_lane <= wb_lane;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (wb && (bus.pipe_saveout != wb_last)) bus.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched with a behavioural MAC model: result = C + A,
// returned LAT cycles after the accepting edge, save flag delayed alongside.
module tb_pipe_sched;
  localparam int LAT = 4;

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] data;
    logic [31:0] cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_nosave = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  res_t q[$];

  logic [15:0] md [LAT-1];
  logic        ms [LAT-1];

  pipe_sched_if #(.LANES(4)) bus ();

  pipe_sched #(.LAT(LAT), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: pipe regs count as the first of LAT stages, so LAT-1 more here.
  always @(posedge clk) begin
    md[0] <= bus.pipe_c + {8'h00, bus.pipe_a};
    ms[0] <= bus.pipe_save & ~force_nosave;
    for (int i = 1; i < LAT - 1; i++) begin
      md[i] <= md[i-1];
      ms[i] <= ms[i-1];
    end
  end
  assign bus.pipe_result  = md[LAT-2];
  assign bus.pipe_saveout = ms[LAT-2];

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back('{lane: bus.out_lane, data: bus.out_data, cyc: cyc});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] l, input logic [7:0] a, input logic f,
                      input logic la, output int acc_cyc);
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_lane  = l;
    bus.in_a     = a;
    bus.in_b     = 8'h01;
    bus.in_afmt  = a[0];
    bus.in_bfmt  = 1'b0;
    bus.in_first = f;
    bus.in_last  = la;
    ok = 1'b0;
    acc_cyc = -1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      if (ok) acc_cyc = cyc;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed lane %0d not accepted expected accept", l);
    end
  endtask

  task automatic wait_out(output res_t r);
    int n;
    n = 0;
    while (q.size() == 0 && n < 60) begin
      step();
      n++;
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL out_timeout observed no result expected result");
      r = '0;
    end else begin
      r = q.pop_front();
    end
  endtask

  initial begin
    int   t0, t1, t2, ta;
    res_t r;
    bus.in_valid  = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_afmt   = 1'b0;
    bus.in_bfmt   = 1'b0;
    bus.in_lane   = '0;
    bus.in_first  = 1'b1;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pipe_en", bus.pipe_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;

    // First op after reset, first & last together
    send(2'd0, 8'h05, 1'b1, 1'b1, ta);
    chk("first_pipe_en", bus.pipe_en, 1);
    chk("first_pipe_c", bus.pipe_c, 16'h0000);
    chk("first_pipe_a", bus.pipe_a, 8'h05);
    chk("first_pipe_b", bus.pipe_b, 8'h01);
    chk("first_pipe_save", bus.pipe_save, 1);
    step();
    chk("pipe_en_one_cycle", bus.pipe_en, 0);
    wait_out(r);
    chk("single_data", r.data, 16'h0005);
    chk("single_lane", r.lane, 0);
    repeat (3) step();

    // Single lane hazard spacing
    send(2'd0, 8'd1, 1'b1, 1'b0, t0);
    send(2'd0, 8'd2, 1'b0, 1'b0, t1);
    chk("lane0_op2_c", bus.pipe_c, 16'h0001);
    send(2'd0, 8'd3, 1'b0, 1'b1, t2);
    chk("lane0_op3_c", bus.pipe_c, 16'h0003);
    chk("hazard_gap1", t1 - t0, 5);
    chk("hazard_gap2", t2 - t0, 10);
    wait_out(r);
    chk("dot3_data", r.data, 16'h0006);
    chk("dot3_lane", r.lane, 0);
    chk("dot3_cycle", r.cyc - t0, 14);

    // Four lanes interleaved, 8 products each
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < 4; l++)
        send(2'(l), 8'(l + 1), k == 0, k == 7, ta);
    for (int l = 0; l < 4; l++) begin
      wait_out(r);
      chk("rr_lane", r.lane, l);
      chk("rr_data", r.data, 8 * (l + 1));
    end

    // Output slot full blocks a new last op
    bus.out_ready = 1'b0;
    send(2'd1, 8'd7, 1'b1, 1'b1, ta);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_data", bus.out_data, 16'h0007);
    bus.in_valid = 1'b1;
    bus.in_lane  = 2'd2;
    bus.in_a     = 8'd9;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("out_stall", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    send(2'd2, 8'd9, 1'b1, 1'b1, ta);
    wait_out(r);
    chk("held_lane", r.lane, 1);
    chk("held_data", r.data, 16'h0007);
    wait_out(r);
    chk("after_stall_lane", r.lane, 2);
    chk("after_stall_data", r.data, 16'h0009);

    // Save flag mismatch is sticky
    force_nosave = 1'b1;
    send(2'd3, 8'd2, 1'b1, 1'b1, ta);
    step();
    force_nosave = 1'b0;
    wait_out(r);
    chk("err_set", bus.err, 1);
    send(2'd3, 8'd4, 1'b1, 1'b1, ta);
    wait_out(r);
    chk("err_data", r.data, 16'h0004);
    chk("err_sticky", bus.err, 1);

    // Reset mid-flight discards the pending result and accumulators
    send(2'd0, 8'd3, 1'b0, 1'b1, ta);
    chk("acc0_before_rst", bus.pipe_c, 16'h0008);
    step();
    step();
    #4;
    rst = 1'b1;
    #1;
    chk("midrst_err", bus.err, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_pipe_en", bus.pipe_en, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("no_out_after_rst", q.size(), 0);
    chk("no_valid_after_rst", bus.out_valid, 0);
    send(2'd0, 8'd1, 1'b0, 1'b1, ta);
    chk("acc0_cleared", bus.pipe_c, 16'h0000);
    wait_out(r);
    chk("post_rst_data", r.data, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
